// File: rtl/wb_reg_file_pkg.sv
// Shared widths and constants for the writeback-stage register file.
package wb_reg_file_pkg;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    function automatic logic is_zero_idx(input logic [REG_IDX_W-1:0] idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_data_mux.sv
// MemtoReg 2:1 selector: memory read data or ALU result. Also used by EX forwarding.
module wb_data_mux #(
    parameter int unsigned size = 32
) (
    input  logic            sel_mem_i,
    input  logic [size-1:0] mem_data_i,
    input  logic [size-1:0] alu_data_i,
    output logic [size-1:0] data_o
);

    assign data_o = sel_mem_i ? mem_data_i : alu_data_i;

endmodule

// File: rtl/wb_reg_file.sv
// Writeback stage: selects WB data, commits it to the 32-entry register file,
// serves two bypassed ID read ports and counts committed writes.
module wb_reg_file
    import wb_reg_file_pkg::*;
#(
    parameter int unsigned size = DATA_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 data_i_RegWrite,
    input  logic                 data_i_MemtoReg,
    input  logic [size-1:0]      data_i_final,
    input  logic [size-1:0]      data_i_ALU_out,
    input  logic [REG_IDX_W-1:0] data_i_WriteReg,
    input  logic [REG_IDX_W-1:0] RSaddr_i,
    input  logic [REG_IDX_W-1:0] RTaddr_i,
    output logic [size-1:0]      RSdata_o,
    output logic [size-1:0]      RTdata_o,
    output logic [size-1:0]      wb_data_o,
    output logic [CNT_W-1:0]     wr_count_o
);

    logic [size-1:0]  regs_q [NUM_REGS];
    logic [size-1:0]  regs_d [NUM_REGS];
    logic [CNT_W-1:0] wr_count_q;
    logic [CNT_W-1:0] wr_count_d;
    logic             commit_c;

    wb_data_mux #(.size(size)) u_wb_data_mux (
        .sel_mem_i  (data_i_MemtoReg),
        .mem_data_i (data_i_final),
        .alu_data_i (data_i_ALU_out),
        .data_o     (wb_data_o)
    );

    // Reset suppresses both the commit and the bypass.
    assign commit_c = data_i_RegWrite && !is_zero_idx(data_i_WriteReg) && !rst_i;

    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (commit_c) begin
            regs_d[data_i_WriteReg] = wb_data_o;
            wr_count_d              = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_count_q <= wr_count_d;
        end
    end

    // Each read port resolves independently: $zero, then same-cycle bypass, then array.
    always_comb begin
        RSdata_o = regs_q[RSaddr_i];
        RTdata_o = regs_q[RTaddr_i];
        if (is_zero_idx(RSaddr_i)) begin
            RSdata_o = '0;
        end else if (commit_c && (RSaddr_i == data_i_WriteReg)) begin
            RSdata_o = wb_data_o;
        end
        if (is_zero_idx(RTaddr_i)) begin
            RTdata_o = '0;
        end else if (commit_c && (RTaddr_i == data_i_WriteReg)) begin
            RTdata_o = wb_data_o;
        end
    end

    assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: directed steps plus random traffic
// against an array-based register-file model.
module tb_wb_reg_file;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        data_i_RegWrite;
    logic        data_i_MemtoReg;
    logic [31:0] data_i_final;
    logic [31:0] data_i_ALU_out;
    logic [4:0]  data_i_WriteReg;
    logic [4:0]  RSaddr_i;
    logic [4:0]  RTaddr_i;
    logic [31:0] RSdata_o;
    logic [31:0] RTdata_o;
    logic [31:0] wb_data_o;
    logic [31:0] wr_count_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_regs [32];
    logic [31:0] model_cnt;

    wb_reg_file #(.size(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .data_i_RegWrite (data_i_RegWrite),
        .data_i_MemtoReg (data_i_MemtoReg),
        .data_i_final    (data_i_final),
        .data_i_ALU_out  (data_i_ALU_out),
        .data_i_WriteReg (data_i_WriteReg),
        .RSaddr_i        (RSaddr_i),
        .RTaddr_i        (RTaddr_i),
        .RSdata_o        (RSdata_o),
        .RTdata_o        (RTdata_o),
        .wb_data_o       (wb_data_o),
        .wr_count_o      (wr_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rw, input logic m2r,
                         input logic [31:0] fin, input logic [31:0] alu,
                         input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt);
        rst_i = rst; data_i_RegWrite = rw; data_i_MemtoReg = m2r;
        data_i_final = fin; data_i_ALU_out = alu; data_i_WriteReg = wr;
        RSaddr_i = rs; RTaddr_i = rt;
    endtask

    function automatic logic [31:0] exp_wb();
        return data_i_MemtoReg ? data_i_final : data_i_ALU_out;
    endfunction

    function automatic logic exp_commit();
        return data_i_RegWrite && data_i_WriteReg != 5'd0 && !rst_i;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (exp_commit() && idx == data_i_WriteReg) return exp_wb();
        return model_regs[idx];
    endfunction

    // Check combinational outputs, clock once, advance the model, return at negedge.
    task automatic cycle(input string tag);
        #1;
        check({tag, ".rs"},  RSdata_o,   exp_read(RSaddr_i));
        check({tag, ".rt"},  RTdata_o,   exp_read(RTaddr_i));
        check({tag, ".wb"},  wb_data_o,  exp_wb());
        check({tag, ".cnt"}, wr_count_o, model_cnt);
        @(posedge clk_i);
        if (rst_i) begin
            foreach (model_regs[i]) model_regs[i] = 32'd0;
            model_cnt = 32'd0;
        end else if (exp_commit()) begin
            model_regs[data_i_WriteReg] = exp_wb();
            model_cnt = model_cnt + 32'd1;
        end
        @(negedge clk_i);
    endtask

    initial begin
        foreach (model_regs[i]) model_regs[i] = 32'd0;
        model_cnt = 32'd0;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd31);
        #1;
        check("init.cnt", wr_count_o, 32'd0);
        check("init.rs1", RSdata_o, 32'd0);

        // Preload regs 1..31 with nonzero values.
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, i[0], 32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i),
                  5'(i), 5'(i), 5'(32 - i));
            cycle("preload");
        end
        check("preload.cnt", wr_count_o, 32'd31);

        // Reset colliding with a commit to reg 3: bypass off, stored value read.
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h0000_0055, 5'd3, 5'd3, 5'd3);
        #1;
        check("rstcol.nobypass", RSdata_o, 32'hA000_0003);
        cycle("rstcol");
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd3);
        #1;
        check("rstcol.reg3", RSdata_o, 32'd0);
        check("rstcol.cnt", wr_count_o, 32'd0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'(i), 5'(31 - i));
            cycle("rstclear");
        end

        // Basic write then read.
        drive(1'b0, 1'b1, 1'b0, 32'hCAFE_0000, 32'h0000_1234, 5'd5, 5'd1, 5'd2);
        cycle("basic.wr");
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
        #1;
        check("basic.rd", RSdata_o, 32'h0000_1234);
        check("basic.cnt", wr_count_o, 32'd1);
        cycle("basic.rd");

        // Same-cycle bypass on both ports.
        drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 5'd9, 5'd9, 5'd9);
        #1;
        check("bypass.rs", RSdata_o, 32'hDEAD_BEEF);
        check("bypass.rt", RTdata_o, 32'hDEAD_BEEF);
        cycle("bypass");

        // Writes to $zero are discarded and not counted.
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        #1;
        check("zero.same", RSdata_o, 32'd0);
        cycle("zero");
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9);
        #1;
        check("zero.next", RSdata_o, 32'd0);
        check("zero.cnt", wr_count_o, 32'd2);
        cycle("zero.next");

        // Back-to-back writes to one index: last wins, both counted.
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0AAA, 5'd7, 5'd7, 5'd0);
        cycle("b2b.1");
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0BBB, 32'd0, 5'd7, 5'd0, 5'd7);
        cycle("b2b.2");
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd7);
        #1;
        check("b2b.rd", RSdata_o, 32'h0000_0BBB);
        check("b2b.cnt", wr_count_o, 32'd4);
        cycle("b2b.rd");

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr;
            logic [4:0] rs;
            logic [4:0] rt;
            wr = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, wr, rs, rt);
            cycle("rand");
        end

        // Counter wrap: force the count to all-ones, then one commit.
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        force dut.wr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count_q;
        model_cnt = 32'hFFFF_FFFF;
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0042, 5'd1, 5'd1, 5'd0);
        cycle("wrap");
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd0);
        #1;
        check("wrap.cnt", wr_count_o, 32'd0);
        check("wrap.reg1", RSdata_o, 32'h0000_0042);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
